// File: rtl/rx_pkt_unpack_if.sv
// Link between the RX AXI-stream FIFO, the row unpacker and the classifier pixel port.
// slave is the unpacker's view; master is the surrounding environment's view.
interface rx_pkt_unpack_if;
  logic [7:0] rx_axis_fifo_tdata;
  logic       rx_axis_fifo_tvalid;
  logic       rx_axis_fifo_tlast;
  logic       rx_axis_fifo_tready;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_sol;
  logic       pix_eol;
  logic       pix_ready;

  modport slave (
    input  rx_axis_fifo_tdata,
    input  rx_axis_fifo_tvalid,
    input  rx_axis_fifo_tlast,
    output rx_axis_fifo_tready,
    output pix_data,
    output pix_valid,
    output pix_sol,
    output pix_eol,
    input  pix_ready
  );

  modport master (
    output rx_axis_fifo_tdata,
    output rx_axis_fifo_tvalid,
    output rx_axis_fifo_tlast,
    input  rx_axis_fifo_tready,
    input  pix_data,
    input  pix_valid,
    input  pix_sol,
    input  pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/rx_pkt_unpack.sv
// Row unpacker: length-checks RX packets into a ping-pong RAM and replays good rows as pixels, 3 cycles after tlast.
// tready drops only while both banks are full; pixel stalls are absorbed losslessly by an output register plus skid entry.
module rx_pkt_unpack #(
  parameter int PKT_LEN = 629,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  rx_pkt_unpack_if.slave   bus,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] err_short_cnt,
  output logic [CNT_W-1:0] err_long_cnt
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);

  typedef struct packed {
    logic       sol;
    logic       eol;
    logic [7:0] dat;
  } pix_t;

  typedef enum logic {W_RECV, W_DISCARD} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  logic [7:0] mem [0:(2**(ADDR_W+1))-1];
  logic [1:0] full;

  // ---------------- write side ----------------
  wr_state_t         wr_state, wr_state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_bank;
  logic              rx_rdy, wr_en, wr_commit, wr_short, wr_long, wr_clr;

  always_ff @(posedge clk) begin
    if (rst) wr_state <= W_RECV;
    else     wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    rx_rdy       = 1'b0;
    wr_en        = 1'b0;
    wr_commit    = 1'b0;
    wr_short     = 1'b0;
    wr_long      = 1'b0;
    wr_clr       = 1'b0;
    case (wr_state)
      W_RECV: begin
        rx_rdy = !full[wr_bank] && !rst;
        if (bus.rx_axis_fifo_tvalid && rx_rdy) begin
          if (bus.rx_axis_fifo_tlast) begin
            wr_clr = 1'b1;
            if (wr_cnt == LAST_IDX) begin
              wr_en     = 1'b1;
              wr_commit = 1'b1;
            end else begin
              wr_short  = 1'b1;
            end
          end else if (wr_cnt == LAST_IDX) begin
            // Over-length beat is not stored; the rest of the packet is swallowed.
            wr_clr       = 1'b1;
            wr_long      = 1'b1;
            wr_state_nxt = W_DISCARD;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      W_DISCARD: begin
        rx_rdy = !rst;
        if (bus.rx_axis_fifo_tvalid && rx_rdy && bus.rx_axis_fifo_tlast)
          wr_state_nxt = W_RECV;
      end
      default: wr_state_nxt = W_RECV;
    endcase
  end

  assign bus.rx_axis_fifo_tready = rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else begin
      if (wr_clr)     wr_cnt <= '0;
      else if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (wr_commit)  wr_bank <= !wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= bus.rx_axis_fifo_tdata;
  end

  // ---------------- read side ----------------
  rd_state_t         rd_state, rd_state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank, rd_done, rd_en, rd_release;
  logic [7:0]        ram_q;
  logic              r_vld, r_sol, r_eol;
  pix_t              r_pix, o_pix, s_pix;
  logic              o_vld, s_vld, pop, room;
  logic [1:0]        occ;

  assign pop   = o_vld && bus.pix_ready;
  assign occ   = 2'(o_vld) + 2'(s_vld) + 2'(r_vld);
  // A read issued now lands next cycle and must find a free slot in output/skid.
  assign room  = (occ - 2'(pop)) < 2'd2;
  assign r_pix = {r_sol, r_eol, ram_q};

  always_ff @(posedge clk) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_en        = 1'b0;
    rd_release   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          rd_state_nxt = R_READ;
          rd_en        = room;
        end
      end
      R_READ: begin
        rd_en = !rd_done && room;
        if (pop && o_pix.eol) begin
          rd_release   = 1'b1;
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      rd_done <= 1'b0;
      rd_bank <= 1'b0;
      r_vld   <= 1'b0;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
    end else begin
      r_vld <= rd_en;
      if (rd_en) begin
        r_sol   <= (rd_addr == '0);
        r_eol   <= (rd_addr == LAST_IDX);
        rd_addr <= rd_addr + 1'b1;
        if (rd_addr == LAST_IDX) rd_done <= 1'b1;
      end
      if (rd_release) begin
        rd_addr <= '0;
        rd_done <= 1'b0;
        rd_bank <= !rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[{rd_bank, rd_addr}];
  end

  // Output register is always the oldest item; skid only fills while output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld <= 1'b0;
      s_vld <= 1'b0;
      o_pix <= '0;
      s_pix <= '0;
    end else if (!o_vld || pop) begin
      if (s_vld) begin
        o_vld <= 1'b1;
        o_pix <= s_pix;
        s_vld <= r_vld;
        if (r_vld) s_pix <= r_pix;
      end else begin
        o_vld <= r_vld;
        if (r_vld) o_pix <= r_pix;
      end
    end else if (r_vld) begin
      s_vld <= 1'b1;
      s_pix <= r_pix;
    end
  end

  assign bus.pix_valid = o_vld;
  assign bus.pix_data  = o_pix.dat;
  assign bus.pix_sol   = o_pix.sol;
  assign bus.pix_eol   = o_pix.eol;

  // ---------------- bank flags and statistics ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      full          <= 2'b00;
      row_cnt       <= '0;
      err_short_cnt <= '0;
      err_long_cnt  <= '0;
    end else begin
      full <= (full | (2'(wr_commit) << wr_bank)) & ~(2'(rd_release) << rd_bank);
      if (rd_release) row_cnt <= row_cnt + 1'b1;
      if (wr_short && (err_short_cnt != '1)) err_short_cnt <= err_short_cnt + 1'b1;
      if (wr_long && (err_long_cnt != '1))   err_long_cnt  <= err_long_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rx_pkt_unpack.sv
// Bench for rx_pkt_unpack: directed scenarios with random payloads, checked against a queue-based packet model.
module tb_rx_pkt_unpack;
  localparam int PKT_LEN = 629;
  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 16;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] row_cnt, err_short_cnt, err_long_cnt;

  rx_pkt_unpack_if bus_if ();

  rx_pkt_unpack #(.PKT_LEN(PKT_LEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .row_cnt      (row_cnt),
    .err_short_cnt(err_short_cnt),
    .err_long_cnt (err_long_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected pixels {sol, eol, data}, rows delivered, dropped packets
  logic [9:0] exp_q[$];
  int exp_rows = 0, exp_short = 0, exp_long = 0;
  int tlast_cyc = 0, first_cyc = -100;
  bit lat_arm = 1'b0;

  int ready_mode = 0;  // 0 fixed, 1 toggle, 2 random
  bit ready_fix  = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       bus_if.pix_ready = !bus_if.pix_ready;
      2:       bus_if.pix_ready = ($urandom_range(0, 1) == 1);
      default: bus_if.pix_ready = ready_fix;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Pixel monitor: order, framing, stability under stall
  bit prev_stall = 1'b0;
  logic [9:0] prev_pix = '0;
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] e;
    cur = {bus_if.pix_sol, bus_if.pix_eol, bus_if.pix_data};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus_if.pix_valid, 1);
        chk("stall_hold", cur, prev_pix);
      end
      if (bus_if.pix_valid) begin
        if (lat_arm) begin
          first_cyc = cyc;
          lat_arm   = 1'b0;
        end
        if (bus_if.pix_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_pix", bus_if.pix_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("pix", cur, e);
            if (e[8]) exp_rows++;
          end
        end
      end
      prev_stall = bus_if.pix_valid && !bus_if.pix_ready;
      prev_pix   = cur;
    end
  end

  task automatic model_pkt(input int len, input logic [7:0] d[$]);
    if (len == PKT_LEN) begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == 0, i == PKT_LEN - 1, d[i]});
    end else if (len < PKT_LEN) begin
      if (exp_short < SAT) exp_short++;
    end else begin
      if (exp_long < SAT) exp_long++;
    end
  endtask

  task automatic wait_rdy();
    for (int w = 0; w < 4000 && !bus_if.rx_axis_fifo_tready; w++) @(negedge clk);
    if (!bus_if.rx_axis_fifo_tready) begin
      chk("tready_timeout", bus_if.rx_axis_fifo_tready, 1);
      finish_run();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the tlast beat is taken.
  task automatic send_pkt(input int len, input bit rnd, input bit chk_disc);
    logic [7:0] d[$];
    for (int i = 0; i < len; i++) d.push_back(rnd ? 8'($urandom) : 8'(i));
    for (int i = 0; i < len; i++) begin
      bus_if.rx_axis_fifo_tdata  = d[i];
      bus_if.rx_axis_fifo_tvalid = 1'b1;
      bus_if.rx_axis_fifo_tlast  = (i == len - 1);
      @(negedge clk);
      if (chk_disc && i >= PKT_LEN) chk("discard_rdy", bus_if.rx_axis_fifo_tready, 1);
      wait_rdy();
      if (i == len - 1) begin
        tlast_cyc = cyc;
        model_pkt(len, d);
      end
      @(posedge clk);
      #1;
    end
    bus_if.rx_axis_fifo_tvalid = 1'b0;
    bus_if.rx_axis_fifo_tlast  = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.rx_axis_fifo_tdata  = 8'($urandom);
      bus_if.rx_axis_fifo_tvalid = 1'b1;
      bus_if.rx_axis_fifo_tlast  = 1'b0;
      @(negedge clk);
      wait_rdy();
      @(posedge clk);
      #1;
    end
    bus_if.rx_axis_fifo_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    for (w = 0; w < 20000 && (exp_q.size() != 0 || bus_if.pix_valid); w++) @(negedge clk);
    if (exp_q.size() != 0 || bus_if.pix_valid) begin
      chk("drain_timeout", exp_q.size(), 0);
      finish_run();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_rows"},  row_cnt,       CNT_W'(exp_rows));
    chk({tag, "_short"}, err_short_cnt, CNT_W'(exp_short));
    chk({tag, "_long"},  err_long_cnt,  CNT_W'(exp_long));
  endtask

  // Called at posedge+1; holds rst for one edge, checks outputs, returns at posedge+1.
  task automatic do_reset(input string tag);
    bus_if.rx_axis_fifo_tvalid = 1'b0;
    bus_if.rx_axis_fifo_tlast  = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    exp_rows = 0; exp_short = 0; exp_long = 0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_tready"}, bus_if.rx_axis_fifo_tready, 0);
    chk({tag, "_valid"},  bus_if.pix_valid, 0);
    chk({tag, "_pix"},    {bus_if.pix_sol, bus_if.pix_eol, bus_if.pix_data}, 0);
    check_counters(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int len, sel;
    bus_if.rx_axis_fifo_tdata  = '0;
    bus_if.rx_axis_fifo_tvalid = 1'b0;
    bus_if.rx_axis_fifo_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset("reset");
    @(negedge clk);
    chk("idle_tready", bus_if.rx_axis_fifo_tready, 1);
    chk("idle_valid", bus_if.pix_valid, 0);
    @(posedge clk);
    #1;

    // One counting-pattern row at full rate; latency from tlast
    lat_arm = 1'b1;
    send_pkt(PKT_LEN, 1'b0, 1'b0);
    wait_drain();
    chk("latency", first_cyc - tlast_cyc, 3);
    check_counters("one_row");

    // Three rows with the sink stalled: third must wait for a free bank
    ready_fix = 1'b0;
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    @(negedge clk);
    chk("both_full_tready", bus_if.rx_axis_fifo_tready, 0);
    @(posedge clk);
    #1;
    fork
      send_pkt(PKT_LEN, 1'b1, 1'b0);
      begin
        repeat (20) @(negedge clk);
        chk("still_blocked", bus_if.rx_axis_fifo_tready, 0);
        chk("stalled_valid", bus_if.pix_valid, 1);
        chk("stalled_rows", row_cnt, CNT_W'(exp_rows));
        ready_fix = 1'b1;
      end
    join
    wait_drain();
    check_counters("three_rows");

    // Short packet dropped, next row intact
    send_pkt(101, 1'b1, 1'b0);
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    wait_drain();
    check_counters("short");

    // Long packet swallowed with tready high, next row intact
    send_pkt(700, 1'b1, 1'b1);
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    wait_drain();
    check_counters("long");

    // Alternating backpressure
    ready_mode = 1;
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    wait_drain();
    check_counters("toggle");

    // Off-by-one lengths, then a random mix under random backpressure
    ready_mode = 2;
    send_pkt(PKT_LEN - 1, 1'b1, 1'b0);
    send_pkt(PKT_LEN + 1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? $urandom_range(1, PKT_LEN - 1) :
            (sel == 1) ? $urandom_range(PKT_LEN + 1, PKT_LEN + 60) : PKT_LEN;
      send_pkt(len, 1'b1, 1'b0);
    end
    wait_drain();
    check_counters("random");

    // Reset mid-receive, then mid-drain, then a fresh row
    ready_mode = 0;
    ready_fix  = 1'b1;
    send_partial(300);
    do_reset("rst_rx");
    ready_fix = 1'b0;
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    for (int w = 0; w < 50 && !bus_if.pix_valid; w++) @(negedge clk);
    chk("drain_started", bus_if.pix_valid, 1);
    @(posedge clk);
    #1;
    do_reset("rst_drain");
    ready_fix = 1'b1;
    send_pkt(PKT_LEN, 1'b1, 1'b0);
    wait_drain();
    check_counters("after_rst");

    finish_run();
  end
endmodule

// File: doc/rx_pkt_unpack.md
Name: rx_pkt_unpack

Overview:
- Receive-side counterpart of the classifier result packetiser.
- Accepts fixed-length image-row packets from the Ethernet RX AXI-stream FIFO and validates the length against tlast.
- Buffers each good packet in a two-bank ping-pong RAM and replays it as a pixel stream with valid/ready handshake to the classifier front end.
- Bad-length packets are dropped whole and counted.

Parameters:
PKT_LEN, 629, bytes per valid packet (one image row); must be between 2 and 2^ADDR_W inclusive
ADDR_W, 10, address width of one bank; each bank holds 2^ADDR_W bytes
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rx_axis_fifo_tdata  in  8  received byte
rx_axis_fifo_tvalid  in  1  byte valid
rx_axis_fifo_tlast  in  1  last byte of packet
rx_axis_fifo_tready  out  1  byte accepted when tvalid&&tready
pix_data  out  8  pixel byte to classifier
pix_valid  out  1  pixel valid
pix_sol  out  1  first pixel of row, qualified by pix_valid
pix_eol  out  1  last pixel of row, qualified by pix_valid
pix_ready  in  1  downstream accepts pixel when pix_valid&&pix_ready
row_cnt  out  CNT_W  rows fully delivered; wraps
err_short_cnt  out  CNT_W  packets dropped for early tlast; saturating
err_long_cnt  out  CNT_W  packets dropped for missing tlast; saturating

Behaviour:
- Reset:
  - all outputs 0; both banks free; write and read FSMs idle.
  - Write bank pointer and read bank pointer both 0.
  - rst mid-packet abandons all buffered and in-flight data with no counter update.
- Write FSM states: RECV, DISCARD.
  - RECV:
    - rx_axis_fifo_tready = (bank at write pointer free) && !rst.
    - Each accepted beat is written at address wr_cnt of the current bank; wr_cnt then increments.
    - tlast with wr_cnt==PKT_LEN-1: bank is committed (marked full) on the next cycle; write pointer toggles; wr_cnt=0.
    - tlast with wr_cnt<PKT_LEN-1: packet dropped; bank stays free; wr_cnt=0; err_short_cnt+1.
    - wr_cnt==PKT_LEN-1 without tlast: beat dropped; err_long_cnt+1; go to DISCARD.
  - DISCARD:
    - tready=1; beats are consumed and not written.
    - On an accepted tlast: go to RECV with wr_cnt=0.
- Bank status: 2-bit full flags.
  - Commit (write side) and release (read side) in the same cycle on different banks are both applied.
  - Both banks full: tready=0 until a release; no beat is lost.
- Read FSM states: IDLE, READ.
  - IDLE: moves to READ when the bank at the read pointer is full.
  - READ: issues RAM reads (registered output, 1-cycle latency).
  - The output register plus a one-entry skid stage must sustain 1 pixel/cycle while pix_ready=1 and stall losslessly when pix_ready=0.
  - pix_data, pix_sol and pix_eol are held stable while pix_valid&&!pix_ready.
  - Latency: if the tlast beat is accepted in cycle N into an otherwise idle block, first pix_valid=1 in cycle N+3.
  - pix_sol is set on byte 0; pix_eol is set on byte PKT_LEN-1.
  - When the eol beat is accepted: bank released on the same edge; read pointer toggles; row_cnt+1; return to IDLE.
  - A back-to-back full bank may restart reading without a bubble longer than 2 cycles.
- Counters:
  - row_cnt wraps at 2^CNT_W.
  - Error counters saturate at all-ones.
  - All counters are updated on the clock edge following the event.
- Byte order out equals byte order in. Dropped packets never produce pix_valid.

Test Plan:
- One 629-byte packet (data=index mod 256), pix_ready=1 -> 629 pixels in order; pix_sol on byte 0; pix_eol on byte 628 (data 0x74); first pix_valid 3 cycles after tlast; row_cnt=1.
- Three back-to-back packets with pix_ready=0 -> tready drops after the second tlast; raise pix_ready -> 3x629 bytes in order; row_cnt=3; no data lost.
- Packet with tlast on byte 100 -> no pix_valid; err_short_cnt=1; a following good packet is delivered intact.
- 700-byte packet, tlast on byte 699 -> no output; err_long_cnt=1; beats 629..699 consumed with tready=1; next good packet is delivered.
- pix_ready toggling 1/0 each cycle during a row -> no duplicated or skipped bytes; data held stable while stalled.
- rst asserted mid-receive and mid-drain -> all outputs 0 next cycle; a fresh packet afterwards is delivered from bank 0 with row_cnt=1.
